// File: rtl/date_to_daynum.sv
// Date to day-of-year calculator for a two-button board interface.
// KEY[0] steps the month or day being edited, KEY[1] advances through the
// SET_MONTH -> SET_DAY -> CALC -> DONE flow. CALC walks the month-length table
// one month per cycle to accumulate the day-of-year for a non-leap year.
module date_to_daynum #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic [8:0] day_num,
    output logic       valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        SET_MONTH = 2'd0,
        SET_DAY   = 2'd1,
        CALC      = 2'd2,
        DONE      = 2'd3
    } stateT;

    // Terminal count of the debounce counter: the DB_CYCLES-th stable cycle
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    // Days in month m of a non-leap year
    function automatic logic [4:0] monthLen(input logic [3:0] m);
        logic [4:0] len;
        case (m)
            4'd2:                      len = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction

    logic [1:0]       syncA_q;
    logic [1:0]       syncB_q;
    logic [1:0][15:0] dbCnt_q;
    logic [1:0][15:0] dbCnt_d;
    logic [1:0]       pressed_q;
    logic [1:0]       pressed_d;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;

    stateT            state_q;
    stateT            state_d;
    logic [3:0]       month_q;
    logic [3:0]       month_d;
    logic [4:0]       day_q;
    logic [4:0]       day_d;
    logic [8:0]       dayNum_q;
    logic [8:0]       dayNum_d;
    logic             valid_q;
    logic             valid_d;
    logic [8:0]       acc_q;
    logic [8:0]       acc_d;
    logic [3:0]       idx_q;
    logic [3:0]       idx_d;

    logic             incPulse;
    logic             advPulse;

    assign incPulse = pulse_q[0];
    assign advPulse = pulse_q[1];

    // Two-flop synchronizers for the asynchronous push-buttons, idle (released) high
    always_ff @(posedge clk) begin
        if (reset) begin
            syncA_q <= 2'b11;
            syncB_q <= 2'b11;
        end else begin
            syncA_q <= KEY;
            syncB_q <= syncA_q;
        end
    end

    // Debounce: count consecutive cycles the synchronized level disagrees with the
    // accepted level; flip the accepted level after DB_CYCLES, pulsing on a press
    always_comb begin
        dbCnt_d   = dbCnt_q;
        pressed_d = pressed_q;
        pulse_d   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if ((~syncB_q[k]) != pressed_q[k]) begin
                if (dbCnt_q[k] == DB_LAST) begin
                    dbCnt_d[k]   = 16'd0;
                    pressed_d[k] = ~syncB_q[k];
                    pulse_d[k]   = ~syncB_q[k];
                end else begin
                    dbCnt_d[k] = dbCnt_q[k] + 16'd1;
                end
            end else begin
                dbCnt_d[k] = 16'd0;
            end
        end
    end

    // Debounce state and press-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dbCnt_q   <= '0;
            pressed_q <= 2'b00;
            pulse_q   <= 2'b00;
        end else begin
            dbCnt_q   <= dbCnt_d;
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
        end
    end

    // FSM state register together with the date and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SET_MONTH;
            month_q  <= 4'd1;
            day_q    <= 5'd1;
            dayNum_q <= 9'd0;
            valid_q  <= 1'b0;
            acc_q    <= 9'd0;
            idx_q    <= 4'd1;
        end else begin
            state_q  <= state_d;
            month_q  <= month_d;
            day_q    <= day_d;
            dayNum_q <= dayNum_d;
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic; KEY[1] always wins over KEY[0] and CALC ignores both keys
    always_comb begin
        state_d = state_q;
        case (state_q)
            SET_MONTH: if (advPulse) state_d = SET_DAY;
            SET_DAY:   if (advPulse) state_d = CALC;
            CALC:      if (!(idx_q < month_q)) state_d = DONE;
            DONE:      if (advPulse) state_d = SET_MONTH;
            default:   state_d = SET_MONTH;
        endcase
    end

    // Output/datapath logic: field editing, accumulator walk and result capture
    always_comb begin
        month_d  = month_q;
        day_d    = day_q;
        dayNum_d = dayNum_q;
        valid_d  = valid_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        case (state_q)
            SET_MONTH: begin
                if (advPulse) begin
                    day_d   = 5'd1;
                    valid_d = 1'b0;
                end else if (incPulse) begin
                    month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
                    valid_d = 1'b0;
                end
            end
            SET_DAY: begin
                if (advPulse) begin
                    acc_d = {4'd0, day_q};
                    idx_d = 4'd1;
                end else if (incPulse) begin
                    day_d = (day_q == monthLen(month_q)) ? 5'd1 : day_q + 5'd1;
                end
            end
            CALC: begin
                if (idx_q < month_q) begin
                    acc_d = acc_q + {4'd0, monthLen(idx_q)};
                    idx_d = idx_q + 4'd1;
                end else begin
                    dayNum_d = acc_q;
                    valid_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign month   = month_q;
    assign day     = day_q;
    assign day_num = dayNum_q;
    assign valid   = valid_q;
    assign state   = state_q;

endmodule

// File: tb/tb_date_to_daynum.sv
// Directed self-checking bench for date_to_daynum with a short debounce time.
module tb_date_to_daynum;

    logic       clk;
    logic       reset;
    logic [1:0] KEY;
    logic [3:0] month;
    logic [4:0] day;
    logic [8:0] day_num;
    logic       valid;
    logic [1:0] state;

    int assertCount = 0;
    int failCount   = 0;
    int calcCycles  = 0;
    int calcStart   = 0;

    date_to_daynum #(.DB_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .KEY     (KEY),
        .month   (month),
        .day     (day),
        .day_num (day_num),
        .valid   (valid),
        .state   (state)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of cycles spent in CALC, sampled away from the active edge
    always @(negedge clk) begin
        if (state == 2'd2) calcCycles++;
    end

    // Compare an observed value against the bench's expected value
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press the keys selected by mask (bit set = pressed) long enough to debounce, then release
    task automatic applyStimulus(input logic [1:0] mask);
        KEY = ~mask;
        repeat (8) @(negedge clk);
        KEY = 2'b11;
        repeat (8) @(negedge clk);
    endtask

    // Wait a bounded number of cycles for the FSM to reach a state
    task automatic waitForState(input logic [1:0] target, input int maxCycles, input string tag);
        int n;
        n = 0;
        while (state !== target && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 16'(state), 16'(target));
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        KEY   = 2'b11;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_state", 16'(state), 16'd0);
        checkOutput("rst_month", 16'(month), 16'd1);
        checkOutput("rst_day", 16'(day), 16'd1);
        checkOutput("rst_daynum", 16'(day_num), 16'd0);
        checkOutput("rst_valid", 16'(valid), 16'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] January 1st");
        applyStimulus(2'b10);
        checkOutput("jan_setday_state", 16'(state), 16'd1);
        checkOutput("jan_setday_day", 16'(day), 16'd1);
        calcStart = calcCycles;
        applyStimulus(2'b10);
        waitForState(2'd3, 40, "jan_done_timeout");
        checkOutput("jan_daynum", 16'(day_num), 16'd1);
        checkOutput("jan_valid", 16'(valid), 16'd1);
        checkOutput("jan_calc_cycles", 16'(calcCycles - calcStart), 16'd1);

        $display("[TB] DONE ignores KEY[0], then March 1st");
        applyStimulus(2'b01);
        checkOutput("done_inc_month", 16'(month), 16'd1);
        checkOutput("done_inc_state", 16'(state), 16'd3);
        applyStimulus(2'b10);
        checkOutput("done_adv_state", 16'(state), 16'd0);
        checkOutput("done_adv_valid", 16'(valid), 16'd1);
        checkOutput("done_adv_daynum", 16'(day_num), 16'd1);
        applyStimulus(2'b01);
        checkOutput("mar_month2", 16'(month), 16'd2);
        checkOutput("mar_valid_clr", 16'(valid), 16'd0);
        applyStimulus(2'b01);
        checkOutput("mar_month3", 16'(month), 16'd3);
        applyStimulus(2'b10);
        calcStart = calcCycles;
        applyStimulus(2'b10);
        waitForState(2'd3, 40, "mar_done_timeout");
        checkOutput("mar_daynum", 16'(day_num), 16'd60);
        checkOutput("mar_calc_cycles", 16'(calcCycles - calcStart), 16'd3);

        $display("[TB] December 31st");
        doReset();
        for (int i = 0; i < 11; i++) applyStimulus(2'b01);
        checkOutput("dec_month", 16'(month), 16'd12);
        applyStimulus(2'b10);
        for (int i = 0; i < 30; i++) applyStimulus(2'b01);
        checkOutput("dec_day", 16'(day), 16'd31);
        calcStart = calcCycles;
        applyStimulus(2'b10);
        waitForState(2'd3, 40, "dec_done_timeout");
        checkOutput("dec_daynum", 16'(day_num), 16'd365);
        checkOutput("dec_calc_cycles", 16'(calcCycles - calcStart), 16'd12);
        applyStimulus(2'b10);
        applyStimulus(2'b01);
        checkOutput("dec_month_wrap", 16'(month), 16'd1);
        checkOutput("dec_wrap_valid", 16'(valid), 16'd0);

        $display("[TB] Day wrap in February and April");
        applyStimulus(2'b01);
        applyStimulus(2'b10);
        for (int i = 0; i < 27; i++) applyStimulus(2'b01);
        checkOutput("feb_day28", 16'(day), 16'd28);
        applyStimulus(2'b01);
        checkOutput("feb_day_wrap", 16'(day), 16'd1);
        applyStimulus(2'b10);
        waitForState(2'd3, 40, "feb_done_timeout");
        checkOutput("feb1_daynum", 16'(day_num), 16'd32);
        applyStimulus(2'b10);
        applyStimulus(2'b01);
        applyStimulus(2'b01);
        checkOutput("apr_month", 16'(month), 16'd4);
        applyStimulus(2'b10);
        for (int i = 0; i < 29; i++) applyStimulus(2'b01);
        checkOutput("apr_day30", 16'(day), 16'd30);
        applyStimulus(2'b01);
        checkOutput("apr_day_wrap", 16'(day), 16'd1);

        $display("[TB] Glitch rejection and simultaneous keys");
        doReset();
        KEY = 2'b10;
        repeat (3) @(negedge clk);
        KEY = 2'b11;
        repeat (10) @(negedge clk);
        checkOutput("glitch0_month", 16'(month), 16'd1);
        KEY = 2'b01;
        repeat (3) @(negedge clk);
        KEY = 2'b11;
        repeat (10) @(negedge clk);
        checkOutput("glitch1_state", 16'(state), 16'd0);
        applyStimulus(2'b11);
        checkOutput("both_state", 16'(state), 16'd1);
        checkOutput("both_month", 16'(month), 16'd1);

        $display("[TB] Reset during CALC for July");
        applyStimulus(2'b10);
        waitForState(2'd3, 40, "jul_pre_done_timeout");
        applyStimulus(2'b10);
        for (int i = 0; i < 6; i++) applyStimulus(2'b01);
        checkOutput("jul_month", 16'(month), 16'd7);
        applyStimulus(2'b10);
        KEY = 2'b01;
        waitForState(2'd2, 20, "jul_calc_timeout");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        KEY   = 2'b10;
        @(negedge clk);
        checkOutput("calc_rst_state", 16'(state), 16'd0);
        checkOutput("calc_rst_month", 16'(month), 16'd1);
        checkOutput("calc_rst_day", 16'(day), 16'd1);
        checkOutput("calc_rst_daynum", 16'(day_num), 16'd0);
        checkOutput("calc_rst_valid", 16'(valid), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_key_early", 16'(month), 16'd1);
        repeat (5) @(negedge clk);
        checkOutput("held_key_late", 16'(month), 16'd2);
        KEY = 2'b11;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/date_to_daynum.md
DATE_TO_DAYNUM -- requirements
Module: date_to_daynum

Interface
REQ-001 Parameter: DB_CYCLES, default 50000, number of consecutive stable-low clock cycles before a key press is accepted (legal 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 KEY  input  2  raw board push-buttons, active-low; KEY[0] = increment field, KEY[1] = advance/confirm.
REQ-005 month  output  4  current month, 1..12.
REQ-006 day  output  5  current day of month, 1..31.
REQ-007 day_num  output  9  computed day-of-year, 1..365 (non-leap year); 0 when none computed.
REQ-008 valid  output  1  high while day_num holds the result for the current month/day.
REQ-009 state  output  2  FSM state: 0 SET_MONTH, 1 SET_DAY, 2 CALC, 3 DONE.

Function
REQ-010 Each KEY bit SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each key SHALL produce exactly one single-cycle press pulse once its synchronized level has been low for DB_CYCLES consecutive cycles. No further pulse until the level has been high for DB_CYCLES consecutive cycles.
REQ-012 Press pulses SHALL be ignored in CALC. If both pulses occur in the same cycle, the KEY[1] pulse is acted on and the KEY[0] pulse is discarded.
REQ-013 SET_MONTH: KEY[0] pulse increments month, wrapping 12->1; KEY[1] pulse sets day=1, valid=0 and enters SET_DAY.
REQ-014 SET_DAY: KEY[0] pulse increments day, wrapping len(month)->1.
REQ-015 Month lengths: 31,28,31,30,31,30,31,31,30,31,30,31; a KEY[1] pulse in SET_DAY enters CALC.
REQ-016 CALC entry SHALL load accumulator = day and index = 1.
REQ-017 CALC, each subsequent cycle: if index < month, accumulator += len(index) and index increments; otherwise day_num = accumulator, valid = 1, and the FSM enters DONE.
REQ-018 CALC latency: the FSM SHALL occupy CALC for exactly month cycles (January: 1 cycle; December: 12 cycles).
REQ-019 The accumulator and day_num SHALL be 9 bits wide; no overflow is possible (maximum 365).
REQ-020 DONE: day_num and valid hold; KEY[0] pulses are ignored; a KEY[1] pulse enters SET_MONTH with month retained, day retained, and valid still 1.
REQ-021 The first KEY[0] pulse in SET_MONTH after DONE SHALL clear valid to 0 in the same cycle that month changes.
REQ-022 month, day, day_num and valid SHALL change only on the conditions stated above.

Reset
REQ-023 While reset is high at a clock edge: state=SET_MONTH, month=1, day=1, day_num=0, valid=0, accumulator=0, index=1, debounce counters=0, synchronizers=1 (released), all press pulses suppressed.
REQ-024 Reset SHALL take priority over every other event, including mid-CALC and mid-debounce; a held key after reset release requires a full DB_CYCLES low count before it is accepted.

Verification (DB_CYCLES=4)
REQ-025 Reset, then press KEY[1] twice with no month/day change -> CALC lasts 1 cycle; day_num=1, valid=1, state=3.
REQ-026 Press KEY[0] twice (month=3), KEY[1], then KEY[1] -> CALC lasts 3 cycles; day_num=60.
REQ-027 Set month=12 (11 KEY[0]), KEY[1], day=31 (30 KEY[0]), KEY[1] -> day_num=365 after 12 CALC cycles; a further KEY[0] on month=12 wraps it to 1.
REQ-028 month=2, KEY[1], 28 KEY[0] pulses -> day wraps 28->1; month=4 with 30 pulses -> day wraps 30->1.
REQ-029 Key low for 3 cycles then high (glitch) -> no pulse; KEY[0] and KEY[1] pulses in the same cycle in SET_MONTH -> state=SET_DAY, month unchanged.
REQ-030 Assert reset during CALC for month=7 -> next cycle state=0, month=1, day=1, day_num=0, valid=0.
